// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed seven-segment driver.
// Scan advances on synchronised rising edges of div_clock.
module seg7_scan_driver #(
  parameter int unsigned LEADING_ZERO_BLANK = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_clock,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp_n
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       prev_q, prev_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_n_q, dp_n_d;

  logic       tick;
  logic [1:0] nxt;
  logic [3:0] nib;
  logic       hi_zero;
  logic       blank_dig;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Digit selection: next index, its nibble and blanking status
  always_comb begin
    nxt = idx_q + 2'd1;
    nib = value[{nxt, 2'b00} +: 4];
    hi_zero = 1'b0;
    case (nxt)
      2'd1:    hi_zero = (value[15:4] == 12'h000);
      2'd2:    hi_zero = (value[15:8] == 8'h00);
      2'd3:    hi_zero = (value[15:12] == 4'h0);
      default: hi_zero = 1'b0;
    endcase
    blank_dig = (LEADING_ZERO_BLANK != 0) && hi_zero;
  end

  // Next-state: synchroniser, edge detect, scan index and outputs
  always_comb begin
    s1_d    = div_clock;
    s2_d    = s1_q;
    prev_d  = s2_q;
    tick    = s2_q & ~prev_q;
    idx_d   = idx_q;
    anode_d = anode_q;
    seg_d   = seg_q;
    dp_n_d  = dp_n_q;
    if (!enable) begin
      anode_d = 4'b1111;
      seg_d   = 7'b1111111;
      dp_n_d  = 1'b1;
    end else if (tick) begin
      idx_d = nxt;
      if (blank_dig) begin
        anode_d = 4'b1111;
        seg_d   = 7'b1111111;
        dp_n_d  = 1'b1;
      end else begin
        anode_d = ~(4'b0001 << nxt);
        seg_d   = glyph(nib);
        dp_n_d  = ~dp[nxt];
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      idx_q   <= 2'd3;
      anode_q <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_n_q  <= 1'b1;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_n_q  <= dp_n_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp_n  = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of the scan driver,
// with and without leading-zero blanking.
module tb_seg7_scan_driver;

  localparam logic [11:0] BLANK = 12'b1111_1111111_1;

  logic        clock = 1'b0;
  logic        reset;
  logic        div_clock;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  anode0, anode1;
  logic [6:0]  seg0, seg1;
  logic        dpn0, dpn1;

  logic [11:0] exp0, exp1;
  int          checks = 0;
  int          errors = 0;

  seg7_scan_driver #(.LEADING_ZERO_BLANK(0)) dut0 (
    .clock(clock), .reset(reset), .div_clock(div_clock),
    .enable(enable), .value(value), .dp(dp),
    .anode(anode0), .seg(seg0), .dp_n(dpn0)
  );

  seg7_scan_driver #(.LEADING_ZERO_BLANK(1)) dut1 (
    .clock(clock), .reset(reset), .div_clock(div_clock),
    .enable(enable), .value(value), .dp(dp),
    .anode(anode1), .seg(seg1), .dp_n(dpn1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag);
    checks++;
    assert ({anode0, seg0, dpn0} === exp0) else begin
      errors++;
      $error("FAIL %s lzb0 observed=%b expected=%b",
             tag, {anode0, seg0, dpn0}, exp0);
    end
    checks++;
    assert ({anode1, seg1, dpn1} === exp1) else begin
      errors++;
      $error("FAIL %s lzb1 observed=%b expected=%b",
             tag, {anode1, seg1, dpn1}, exp1);
    end
  endtask

  // Called just after a negedge. Outputs must change exactly at
  // the third negedge (two clocks after div_clock is sampled high).
  task automatic div_edge(input string tag, input int hi,
                          input int lo, input logic [11:0] e0,
                          input logic [11:0] e1);
    div_clock = 1'b1;
    for (int t = 1; t <= hi + lo; t++) begin
      @(negedge clock);
      if (t == 3) begin
        exp0 = e0;
        exp1 = e1;
      end
      check(tag);
      if (t == hi) div_clock = 1'b0;
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      check(tag);
    end
  endtask

  initial begin
    reset     = 1'b0;
    div_clock = 1'b0;
    enable    = 1'b1;
    value     = 16'h12AF;
    dp        = 4'b0100;
    exp0      = BLANK;
    exp1      = BLANK;

    // Reset held 3 cycles with div_clock toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      div_clock = ~div_clock;
      @(negedge clock);
      check("reset");
    end
    div_clock = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    idle("post_reset", 5);

    // Normal scan of 12AF, dp on digit 2
    div_edge("scan_d0", 10, 10, 12'b1110_0001110_1, 12'b1110_0001110_1);
    div_edge("scan_d1", 10, 10, 12'b1101_0001000_1, 12'b1101_0001000_1);
    div_edge("scan_d2", 10, 10, 12'b1011_0100100_0, 12'b1011_0100100_0);
    div_edge("scan_d3", 10, 10, 12'b0111_1111001_1, 12'b0111_1111001_1);
    div_edge("scan_wrap", 10, 10, 12'b1110_0001110_1, 12'b1110_0001110_1);

    // Leading zeros: 0007 with dp request on blanked digit 1
    value = 16'h0007;
    dp    = 4'b0010;
    div_edge("lz7_d1", 10, 10, 12'b1101_1000000_0, BLANK);
    div_edge("lz7_d2", 10, 10, 12'b1011_1000000_1, BLANK);
    div_edge("lz7_d3", 10, 10, 12'b0111_1000000_1, BLANK);
    div_edge("lz7_d0", 10, 10, 12'b1110_1111000_1, 12'b1110_1111000_1);

    // All zero: digit 0 still shows 0
    value = 16'h0000;
    dp    = 4'b0000;
    div_edge("lz0_d1", 10, 10, 12'b1101_1000000_1, BLANK);
    div_edge("lz0_d2", 10, 10, 12'b1011_1000000_1, BLANK);
    div_edge("lz0_d3", 10, 10, 12'b0111_1000000_1, BLANK);
    div_edge("lz0_d0", 10, 10, 12'b1110_1000000_1, 12'b1110_1000000_1);

    // Disable while digit 1 is lit
    value = 16'h12AF;
    div_edge("en_d1", 10, 10, 12'b1101_0001000_1, 12'b1101_0001000_1);
    enable = 1'b0;
    exp0 = BLANK;
    exp1 = BLANK;
    @(negedge clock);
    check("disable_next");
    div_edge("dis_tick1", 10, 10, BLANK, BLANK);
    div_edge("dis_tick2", 10, 10, BLANK, BLANK);
    div_edge("dis_tick3", 10, 10, BLANK, BLANK);
    enable = 1'b1;
    idle("reenable_hold", 4);
    div_edge("reen_d2", 10, 10, 12'b1011_0100100_1, 12'b1011_0100100_1);

    // One-clock pulse, then a 50-clock high level
    dp = 4'b0001;
    div_edge("pulse1_d3", 1, 20, 12'b0111_1111001_1, 12'b0111_1111001_1);
    div_edge("hold50_d0", 50, 10, 12'b1110_0001110_0, 12'b1110_0001110_0);

    // Reset one clock after a rising edge is sampled
    div_clock = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    div_clock = 1'b0;
    exp0 = BLANK;
    exp1 = BLANK;
    idle("midscan_reset", 2);
    reset = 1'b1;
    idle("midscan_release", 8);
    div_edge("after_rst_d0", 10, 10, 12'b1110_0001110_0, 12'b1110_0001110_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
